// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter
//
// Packet-granular round-robin arbiter that shares one AXI-Stream consumer (the fsm_tkeep
// stage) between NS AXI-Stream sources. A source is picked while idle, then its beats are
// forwarded unmodified (zero-latency mux, no buffering) until the beat carrying tlast
// handshakes. Priority then rotates to the source after the one just served. Packets are
// never interleaved, and every packet is followed by one idle cycle.
//
// Parameters:
//   NS - number of source ports (2..16)
//   DW - tdata width per port
//   KW - tkeep width per port
//   IW - source-id width, derived as $clog2(NS)
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   s_tvalid  - per-source valid                   [NS]
//   s_tdata   - per-source data, source i at [i*DW +: DW]
//   s_tkeep   - per-source keep, source i at [i*KW +: KW]
//   s_tlast   - per-source end of packet           [NS]
//   s_tready  - per-source ready, at most one bit high
//   m_tvalid  - valid towards fsm_tkeep
//   m_tdata   - data towards fsm_tkeep
//   m_tkeep   - keep towards fsm_tkeep
//   m_tlast   - last towards fsm_tkeep
//   m_tid     - index of the granted (or last granted) source
//   m_tready  - ready from fsm_tkeep

module axis_pkt_arbiter #(
  parameter int unsigned NS = 4,
  parameter int unsigned DW = 16,
  parameter int unsigned KW = 8,
  localparam int unsigned IW = $clog2(NS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NS-1:0]    s_tvalid,
  input  logic [NS*DW-1:0] s_tdata,
  input  logic [NS*KW-1:0] s_tkeep,
  input  logic [NS-1:0]    s_tlast,
  output logic [NS-1:0]    s_tready,
  output logic             m_tvalid,
  output logic [DW-1:0]    m_tdata,
  output logic [KW-1:0]    m_tkeep,
  output logic             m_tlast,
  output logic [IW-1:0]    m_tid,
  input  logic             m_tready
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q,   ptr_d;

  logic          any_req;
  logic [IW-1:0] winner;
  logic [IW-1:0] cand;
  logic [IW-1:0] ptr_inc;
  logic          last_fire;

  // (base + off) mod NS without a divider; base < NS and off < NS, so one subtract suffices.
  // The extra sum bit keeps the compare exact when NS is a power of two.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                             input int unsigned off);
    logic [IW:0] sum;
    sum = {1'b0, base} + (IW+1)'(off);
    if (sum >= (IW+1)'(NS)) begin
      sum = sum - (IW+1)'(NS);
    end
    return sum[IW-1:0];
  endfunction

  // First requesting source at or after ptr, searching upward and wrapping at NS.
  always_comb begin
    any_req = 1'b0;
    winner  = ptr_q;
    cand    = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      cand = wrap_add(ptr_q, k);
      if (!any_req && s_tvalid[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  // Explicit wrap so ptr never reaches NS for non-power-of-two port counts.
  always_comb begin
    if (grant_q == IW'(NS - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = grant_q + 1'b1;
    end
  end

  // Zero-latency datapath from the granted source; data/keep/last are don't-care when idle.
  always_comb begin
    m_tdata  = s_tdata[grant_q*DW +: DW];
    m_tkeep  = s_tkeep[grant_q*KW +: KW];
    m_tlast  = s_tlast[grant_q];
    m_tvalid = (state_q == StBusy) && s_tvalid[grant_q];
    m_tid    = grant_q;
  end

  // Only the granted source ever sees ready, and only while a packet is in progress.
  always_comb begin
    s_tready = '0;
    if (state_q == StBusy) begin
      s_tready[grant_q] = m_tready;
    end
  end

  assign last_fire = m_tvalid && m_tready && m_tlast;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d = winner;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Hold the grant through source stalls and backpressure; release only on tlast.
        if (last_fire) begin
          state_d = StIdle;
          ptr_d   = ptr_inc;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a transaction-level model built from per-source packet
// queues. A second NS=3 instance exercises the non-power-of-two pointer wrap.

module tb_axis_pkt_arbiter;

  localparam int NS = 4;
  localparam int DW = 16;
  localparam int KW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    s_tvalid;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*KW-1:0] s_tkeep;
  logic [NS-1:0]    s_tlast;
  logic [NS-1:0]    s_tready;
  logic             m_tvalid;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tlast;
  logic [1:0]       m_tid;
  logic             m_tready;

  // NS=3 instance
  logic [2:0]       v_tvalid;
  logic [3*DW-1:0]  v_tdata;
  logic [3*KW-1:0]  v_tkeep;
  logic [2:0]       v_tlast;
  logic [2:0]       v_tready;
  logic             v_mvalid;
  logic [DW-1:0]    v_mdata;
  logic [KW-1:0]    v_mkeep;
  logic             v_mlast;
  logic [1:0]       v_mtid;
  logic             v_mready;

  always #5 clk = ~clk;

  axis_pkt_arbiter #(.NS(NS), .DW(DW), .KW(KW)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tready (m_tready)
  );

  axis_pkt_arbiter #(.NS(3), .DW(DW), .KW(KW)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (v_tvalid),
    .s_tdata  (v_tdata),
    .s_tkeep  (v_tkeep),
    .s_tlast  (v_tlast),
    .s_tready (v_tready),
    .m_tvalid (v_mvalid),
    .m_tdata  (v_mdata),
    .m_tkeep  (v_mkeep),
    .m_tlast  (v_mlast),
    .m_tid    (v_mtid),
    .m_tready (v_mready)
  );

  // Reference model: pending beats per source, who owns the output, who has priority next.
  beat_t         srcq[NS][$];
  logic [NS-1:0] en;
  int            owner;
  int            prio;
  int            last_tid;
  int            dut_log[$];
  int            v_log[$];
  int            want_q[$];
  int            hs_cnt;
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc;
  int            rs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic src_req(input int i);
    return en[i] && (srcq[i].size() > 0);
  endfunction

  function automatic logic pending();
    logic p;
    p = 1'b0;
    for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic add_pkt(input int src, input int len, input bit rnd);
    beat_t x;
    for (int b = 0; b < len; b++) begin
      x.data = rnd ? DW'($urandom) : DW'(src * 16 + b);
      x.keep = rnd ? KW'($urandom) : ((b == len - 1) ? 8'h0F : 8'hFF);
      x.last = (b == len - 1);
      srcq[src].push_back(x);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      s_tvalid[i] = src_req(i);
      if (srcq[i].size() > 0) begin
        s_tdata[i*DW +: DW] = srcq[i][0].data;
        s_tkeep[i*KW +: KW] = srcq[i][0].keep;
        s_tlast[i]          = srcq[i][0].last;
      end else begin
        s_tdata[i*DW +: DW] = '0;
        s_tkeep[i*KW +: KW] = '0;
        s_tlast[i]          = 1'b0;
      end
    end
  endtask

  task automatic check();
    logic [NS-1:0] er;
    logic          ev;
    ev = (owner >= 0) && src_req(owner);
    er = '0;
    if (owner >= 0 && m_tready) er = NS'(1) << owner;
    chk("m_tvalid", m_tvalid, ev);
    chk("s_tready", s_tready, er);
    chk("m_tid", m_tid, last_tid);
    if (ev) begin
      chk("m_tdata", m_tdata, srcq[owner][0].data);
      chk("m_tkeep", m_tkeep, srcq[owner][0].keep);
      chk("m_tlast", m_tlast, srcq[owner][0].last);
    end
    if (m_tvalid === 1'b1 && m_tready) begin
      hs_cnt++;
      if (m_tlast === 1'b1) dut_log.push_back(int'(m_tid));
    end
  endtask

  task automatic update();
    beat_t b;
    int    i;
    if (owner < 0) begin
      for (int k = 0; k < NS; k++) begin
        i = (prio + k) % NS;
        if (owner < 0 && src_req(i)) begin
          owner    = i;
          last_tid = i;
        end
      end
    end else if (src_req(owner) && m_tready) begin
      b = srcq[owner].pop_front();
      if (b.last) begin
        prio  = (owner + 1) % NS;
        owner = -1;
      end
    end
  endtask

  // One clock: drive, check mid-cycle, advance the model on the edge.
  task automatic step();
    drive();
    #2;
    check();
    @(posedge clk);
    if (!rst) update();
    #1;
  endtask

  task automatic drain(input string tag, input int max);
    int c;
    c = 0;
    while (pending() && c < max) begin
      step();
      c++;
    end
    chk(tag, pending(), 1'b0);
  endtask

  task automatic check_log(input string tag, input int got[$], input int want[$]);
    chk({tag, "_count"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++) chk(tag, got[i], want[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    owner = -1; prio = 0; last_tid = 0; hs_cnt = 0;
    en = '0; m_tready = 1'b1;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
    v_tvalid = '0; v_tdata = '0; v_tkeep = '0; v_tlast = '0; v_mready = 1'b0;

    // Reset held with every source requesting, then round-robin over 3-beat packets.
    for (int i = 0; i < NS; i++) begin
      add_pkt(i, 3, 1'b0);
      add_pkt(i, 3, 1'b0);
    end
    en = '1;
    repeat (3) step();
    rst = 1'b0;
    dut_log.delete();
    drain("rr_drain", 200);
    want_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_log("rr_order", dut_log, want_q);

    // Only sources 1 and 3 request single-beat packets.
    dut_log.delete();
    en = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      add_pkt(1, 1, 1'b0);
      add_pkt(3, 1, 1'b0);
    end
    drain("skip_drain", 100);
    want_q = '{1, 3, 1, 3, 1, 3};
    check_log("skip_order", dut_log, want_q);

    // Backpressure: m_tready pattern 1,0,0,1 repeating during a 4-beat packet from source 2.
    dut_log.delete();
    hs_cnt = 0;
    en = 4'b0100;
    add_pkt(2, 4, 1'b0);
    cyc = 0;
    while (pending() && cyc < 60) begin
      m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      step();
      cyc++;
    end
    chk("bp_drain", pending(), 1'b0);
    chk("bp_beats", hs_cnt, 4);
    m_tready = 1'b1;
    want_q = '{2};
    check_log("bp_order", dut_log, want_q);

    // Granted source 1 stalls for 5 cycles mid-packet while source 0 requests.
    dut_log.delete();
    add_pkt(1, 4, 1'b0);
    add_pkt(0, 2, 1'b0);
    en = 4'b0010;
    repeat (3) step();
    en = 4'b0001;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("stall_grant", m_tid, 1);
      chk("stall_rdy0", s_tready[0], 1'b0);
    end
    en = 4'b0011;
    drain("stall_drain", 100);
    want_q = '{1, 0};
    check_log("stall_order", dut_log, want_q);

    // Reset asserted between beats 2 and 3 of a source-3 packet; outputs clear at once.
    dut_log.delete();
    add_pkt(3, 4, 1'b0);
    en = 4'b1000;
    repeat (3) step();
    drive();
    #2;
    rst = 1'b1;
    #1;
    owner = -1; prio = 0; last_tid = 0;
    for (int i = 0; i < NS; i++) srcq[i].delete();
    chk("rst_mvalid", m_tvalid, 1'b0);
    chk("rst_tready", s_tready, 4'b0000);
    chk("rst_tid", m_tid, 0);
    @(posedge clk);
    #1;
    repeat (2) step();
    rst = 1'b0;
    add_pkt(3, 1, 1'b0);
    add_pkt(1, 1, 1'b0);
    en = 4'b1010;
    drain("rst_drain", 50);
    want_q = '{1, 3};
    check_log("rst_order", dut_log, want_q);

    // Randomized traffic, gating and backpressure.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        rs = int'($urandom_range(0, NS - 1));
        if (srcq[rs].size() < 12) add_pkt(rs, int'($urandom_range(1, 4)), 1'b1);
      end
      for (int i = 0; i < NS; i++) en[i] = ($urandom_range(0, 3) != 0);
      m_tready = ($urandom_range(0, 3) != 0);
      step();
    end
    en = '1;
    m_tready = 1'b1;
    drain("rand_drain", 500);

    // NS=3: source 2 alone first, then all three continuously offer single-beat packets.
    v_mready = 1'b1;
    v_tlast  = 3'b111;
    v_tkeep  = '1;
    v_tdata  = {16'd2, 16'd1, 16'd0};
    v_tvalid = 3'b100;
    want_q = '{2, 0, 1, 2, 0};
    cyc = 0;
    while (v_log.size() < 5 && cyc < 40) begin
      #2;
      if (v_mvalid === 1'b1 && v_mready) begin
        chk("ns3_data", v_mdata, DW'(want_q[v_log.size()]));
        v_log.push_back(int'(v_mtid));
      end
      @(posedge clk);
      #1;
      if (v_log.size() >= 1) v_tvalid = 3'b111;
      cyc++;
    end
    check_log("ns3_order", v_log, want_q);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-granular round-robin arbiter that shares one AXI-Stream consumer (the `fsm_tkeep` tkeep-processing stage) between `NS` AXI-Stream sources. It sits directly upstream of `fsm_tkeep`:

- It selects one source, then forwards that source's beats unmodified until the beat carrying `tlast` completes.
- It then rotates priority to the next source.
- Packets are never interleaved.

## Interface
- `NS`, 4 — number of source ports; legal range 2..16.
- `DW`, 16 — tdata width per port.
- `KW`, 8 — tkeep width per port.
- `IW`, `$clog2(NS)` — width of the source-id field (derived, not overridden).

Ports:
- `clk`  in  1 — single clock; all state is updated on the rising edge.
- `rst`  in  1 — asynchronous, active-high reset.
- `s_tvalid`  in  NS — per-source valid.
- `s_tdata`  in  NS*DW — flattened; source i occupies bits [i*DW +: DW].
- `s_tkeep`  in  NS*KW — flattened; source i occupies bits [i*KW +: KW].
- `s_tlast`  in  NS — per-source end of packet.
- `s_tready`  out  NS — per-source ready; at most one bit is high at any time.
- `m_tvalid`  out  1 — valid to `fsm_tkeep`.
- `m_tdata`  out  DW — data to `fsm_tkeep`.
- `m_tkeep`  out  KW — keep to `fsm_tkeep`.
- `m_tlast`  out  1 — last to `fsm_tkeep`.
- `m_tid`  out  IW — index of the currently granted source.
- `m_tready`  in  1 — ready from `fsm_tkeep`.

## Operation
Registered state:
- `state` — IDLE or BUSY.
- `grant` — IW bits; the currently granted source.
- `ptr` — IW bits; the highest-priority source for the next arbitration.

IDLE:
- `s_tready` = 0, `m_tvalid` = 0.
- If any `s_tvalid` bit is high, the winner is the first set bit found searching from `ptr` upward, modulo NS.
- On that edge, `grant` <= winner and `state` <= BUSY.
- If no bit is high, the block stays in IDLE.

BUSY (combinational mux from the granted source g):
- `m_tvalid` = `s_tvalid[g]`, `m_tdata` = `s_tdata[g]`, `m_tkeep` = `s_tkeep[g]`, `m_tlast` = `s_tlast[g]`.
- `s_tready[g]` = `m_tready`; all other `s_tready` bits = 0.
- `m_tid` = g in both states; in IDLE it shows the last granted source.
- When the granted source deasserts `tvalid` mid-packet, the grant is held indefinitely. There is no timeout and no preemption.
- On a handshake (`m_tvalid` && `m_tready`) with `m_tlast` = 1: `state` <= IDLE and `ptr` <= (g+1) mod NS. For non-power-of-2 NS the wrap is explicit; `ptr` never holds a value ≥ NS.
- Handshakes with `m_tlast` = 0 leave the state unchanged.

Reset (asserted; takes effect immediately, without waiting for a clock edge):
- `state` = IDLE, `grant` = 0, `ptr` = 0.
- Outputs: `m_tvalid` = 0, `s_tready` = 0, `m_tid` = 0; `m_tdata`, `m_tkeep` and `m_tlast` are don't-care.
- A packet in flight when reset asserts is abandoned. After reset deasserts, arbitration restarts from source 0.

## Timing
- Arbitration latency:
  - A request seen in IDLE at edge N yields BUSY from edge N.
  - The first beat can transfer in the cycle following edge N.
- Inter-packet bubble: exactly one IDLE cycle after every tlast handshake, including when the same source requests again.
- Datapath latency: 0 cycles. Data, keep and last are combinational from the granted source; there is no buffering.
- Throughput within a packet: one beat per cycle while `s_tvalid[g]` and `m_tready` are both high.
- Single-beat packet: IDLE → BUSY → IDLE, one beat per 2 cycles minimum.
- `m_tready` low in BUSY:
  - the master beat is held stable, because AXIS rules require the source to hold it;
  - `s_tready[g]` = 0;
  - no state change.
- Simultaneous requests: the winner is resolved purely by `ptr`. Requests from non-granted sources have no effect while BUSY.

## Test plan
- **Reset:** hold `rst` = 1 with all `s_tvalid` = 1 → `m_tvalid` = 0, `s_tready` = 0000, `m_tid` = 0. Deassert → source 0 is granted first.
- **Round-robin fairness:** all 4 sources continuously offer 3-beat packets (data = src*16+beat, tkeep = 8'hFF on the first two beats and 8'h0F on the last) → output order is src 0,1,2,3,0,…. Each packet is contiguous, the data and keep match, and there is exactly 1 idle cycle between packets.
- **Pointer skip and wrap:** only sources 1 and 3 request, with single-beat packets → grants alternate 1,3,1,3. With NS = 3, a source-2 grant is followed by `ptr` = 0.
- **Backpressure:** source 2 sends a 4-beat packet while `m_tready` toggles 1,0,0,1,… → no beat is lost or duplicated, `s_tready[2]` mirrors `m_tready`, and `m_tlast` appears only on beat 4.
- **Source stall:** the granted source 1 drops `tvalid` for 5 cycles mid-packet while source 0 requests → the grant stays on 1, `s_tready[0]` = 0 throughout, and source 0 is granted only after source 1's tlast handshake.
- **Reset mid-packet:** assert `rst` between beats 2 and 3 of source 3 → outputs clear immediately. After release, with source 3 and source 1 both requesting, the first grant goes to source 1 (`ptr` = 0).
